// File: rtl/cprv_pkg.sv
// Shared constants and state/owner encodings for the cprv memory arbiter.
package cprv_pkg;

  localparam int DATA_WIDTH = 64;
  localparam int WORD_WIDTH = 32;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_REQ,
    ARB_RSP
  } arb_state_e;

  typedef enum logic {
    OWN_IF,
    OWN_DMEM
  } arb_owner_e;

endpackage

// File: rtl/cprv_mem_arbiter.sv
// Shares one unified memory port between the IF (fetch) and MEM (load/store)
// requesters. One transaction at a time: grant in IDLE, present on the bus in
// REQ, route the single response beat back to the owner in RSP.
import cprv_pkg::*;

module cprv_mem_arbiter #(
  parameter int DATA_WIDTH = cprv_pkg::DATA_WIDTH,
  parameter int WORD_WIDTH = cprv_pkg::WORD_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_if_i,
  output logic                  ready_if_o,
  input  logic [DATA_WIDTH-1:0] addr_if_i,
  output logic                  valid_if_rsp_o,
  input  logic                  ready_if_rsp_i,
  output logic [WORD_WIDTH-1:0] rdata_if_o,
  input  logic                  valid_dmem_i,
  output logic                  ready_dmem_o,
  input  logic [DATA_WIDTH-1:0] addr_dmem_i,
  input  logic [DATA_WIDTH-1:0] wdata_dmem_i,
  input  logic                  w_en_dmem_i,
  output logic                  valid_dmem_rsp_o,
  input  logic                  ready_dmem_rsp_i,
  output logic [DATA_WIDTH-1:0] rdata_dmem_o,
  output logic                  valid_bus_o,
  input  logic                  ready_bus_i,
  output logic [DATA_WIDTH-1:0] addr_bus_o,
  output logic [DATA_WIDTH-1:0] wdata_bus_o,
  output logic                  w_en_bus_o,
  input  logic                  valid_bus_rsp_i,
  output logic                  ready_bus_rsp_o,
  input  logic [DATA_WIDTH-1:0] rdata_bus_i,
  output logic                  busy_o
);

  arb_state_e            r_state;
  arb_state_e            w_nextState;
  arb_owner_e            r_owner;
  arb_owner_e            r_lastGrant;
  logic [DATA_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_wEn;
  logic                  w_grantIf;
  logic                  w_grantDmem;
  logic                  w_ownerRspReady;

  // Grant decision in IDLE; a tie goes to whoever was not served last. Held
  // low while reset is asserted so no ready leaks out during reset.
  always_comb begin
    w_grantIf   = 1'b0;
    w_grantDmem = 1'b0;
    if (rst_n && r_state == ARB_IDLE) begin
      if (valid_if_i && valid_dmem_i) begin
        if (r_lastGrant == OWN_IF) w_grantDmem = 1'b1;
        else                       w_grantIf   = 1'b1;
      end else begin
        w_grantIf   = valid_if_i;
        w_grantDmem = valid_dmem_i;
      end
    end
  end

  assign w_ownerRspReady = (r_owner == OWN_IF) ? ready_if_rsp_i : ready_dmem_rsp_i;

  // Next-state logic for the IDLE -> REQ -> RSP -> IDLE cycle.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ARB_IDLE: if (w_grantIf || w_grantDmem)             w_nextState = ARB_REQ;
      ARB_REQ:  if (ready_bus_i)                          w_nextState = ARB_RSP;
      ARB_RSP:  if (valid_bus_rsp_i && w_ownerRspReady)   w_nextState = ARB_IDLE;
      default:                                            w_nextState = ARB_IDLE;
    endcase
  end

  // State register; reset abandons any in-flight transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ARB_IDLE;
    else        r_state <= w_nextState;
  end

  // Capture the granted request so the bus sees stable fields during REQ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner     <= OWN_IF;
      r_lastGrant <= OWN_IF;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wEn       <= 1'b0;
    end else if (w_grantIf) begin
      r_owner     <= OWN_IF;
      r_lastGrant <= OWN_IF;
      r_addr      <= addr_if_i;
      r_wdata     <= '0;
      r_wEn       <= 1'b0;
    end else if (w_grantDmem) begin
      r_owner     <= OWN_DMEM;
      r_lastGrant <= OWN_DMEM;
      r_addr      <= addr_dmem_i;
      r_wdata     <= wdata_dmem_i;
      r_wEn       <= w_en_dmem_i;
    end
  end

  assign ready_if_o       = w_grantIf;
  assign ready_dmem_o     = w_grantDmem;
  assign valid_bus_o      = (r_state == ARB_REQ);
  assign addr_bus_o       = r_addr;
  assign wdata_bus_o      = r_wdata;
  assign w_en_bus_o       = r_wEn;
  assign ready_bus_rsp_o  = (r_state == ARB_RSP) && w_ownerRspReady;
  assign valid_if_rsp_o   = (r_state == ARB_RSP) && (r_owner == OWN_IF) && valid_bus_rsp_i;
  assign valid_dmem_rsp_o = (r_state == ARB_RSP) && (r_owner == OWN_DMEM) && valid_bus_rsp_i;
  assign rdata_if_o       = r_addr[2] ? rdata_bus_i[DATA_WIDTH-1 -: WORD_WIDTH]
                                      : rdata_bus_i[WORD_WIDTH-1:0];
  assign rdata_dmem_o     = rdata_bus_i;
  assign busy_o           = (r_state != ARB_IDLE);

  // A bus response outside RSP is a protocol error by the memory side.
  a_rspOnlyInRsp: assert property (@(posedge clk) disable iff (!rst_n)
    valid_bus_rsp_i |-> (r_state == ARB_RSP));

endmodule

// File: tb/tb_cprv_mem_arbiter.sv
// Self-checking bench for cprv_mem_arbiter: directed scenarios plus a
// randomized run checked against a transaction-level reference model.
module tb_cprv_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_if_i, ready_if_o, valid_if_rsp_o, ready_if_rsp_i;
  logic [63:0] addr_if_i;
  logic [31:0] rdata_if_o;
  logic        valid_dmem_i, ready_dmem_o, w_en_dmem_i, valid_dmem_rsp_o, ready_dmem_rsp_i;
  logic [63:0] addr_dmem_i, wdata_dmem_i, rdata_dmem_o;
  logic        valid_bus_o, ready_bus_i, w_en_bus_o, valid_bus_rsp_i, ready_bus_rsp_o, busy_o;
  logic [63:0] addr_bus_o, wdata_bus_o, rdata_bus_i;

  int checks   = 0;
  int failures = 0;
  bit modelLastDmem;

  cprv_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .valid_if_i(valid_if_i), .ready_if_o(ready_if_o), .addr_if_i(addr_if_i),
    .valid_if_rsp_o(valid_if_rsp_o), .ready_if_rsp_i(ready_if_rsp_i), .rdata_if_o(rdata_if_o),
    .valid_dmem_i(valid_dmem_i), .ready_dmem_o(ready_dmem_o), .addr_dmem_i(addr_dmem_i),
    .wdata_dmem_i(wdata_dmem_i), .w_en_dmem_i(w_en_dmem_i),
    .valid_dmem_rsp_o(valid_dmem_rsp_o), .ready_dmem_rsp_i(ready_dmem_rsp_i),
    .rdata_dmem_o(rdata_dmem_o),
    .valid_bus_o(valid_bus_o), .ready_bus_i(ready_bus_i), .addr_bus_o(addr_bus_o),
    .wdata_bus_o(wdata_bus_o), .w_en_bus_o(w_en_bus_o),
    .valid_bus_rsp_i(valid_bus_rsp_i), .ready_bus_rsp_o(ready_bus_rsp_o),
    .rdata_bus_i(rdata_bus_i), .busy_o(busy_o)
  );

  // Free-running core clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  task automatic idle_inputs();
    valid_if_i = 0; addr_if_i = '0; ready_if_rsp_i = 0;
    valid_dmem_i = 0; addr_dmem_i = '0; wdata_dmem_i = '0; w_en_dmem_i = 0; ready_dmem_rsp_i = 0;
    ready_bus_i = 0; valid_bus_rsp_i = 0; rdata_bus_i = '0;
  endtask

  task automatic do_reset();
    @(negedge clk); idle_inputs(); rst_n = 0;
    @(negedge clk); rst_n = 1;
    modelLastDmem = 0;
  endtask

  task automatic test_reset();
    idle_inputs(); rst_n = 0; valid_if_i = 1; valid_dmem_i = 1;
    repeat (2) @(negedge clk);
    #2;
    checks++; if (ready_if_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_ready_if got=%0b exp=0", ready_if_o); end
    checks++; if (ready_dmem_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_ready_dmem got=%0b exp=0", ready_dmem_o); end
    checks++; if (valid_bus_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid_bus got=%0b exp=0", valid_bus_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%0b exp=0", busy_o); end
    checks++; if (ready_bus_rsp_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_ready_bus_rsp got=%0b exp=0", ready_bus_rsp_o); end
    checks++; if ({valid_if_rsp_o, valid_dmem_rsp_o} !== 2'b00) begin failures++; $display("[TB] FAIL reset_rsp_valids got=%b exp=00", {valid_if_rsp_o, valid_dmem_rsp_o}); end
    checks++; if (addr_bus_o !== 64'h0 || w_en_bus_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_bus_fields got=%h/%0b exp=0/0", addr_bus_o, w_en_bus_o); end
    @(negedge clk); idle_inputs(); rst_n = 1;
    modelLastDmem = 0;
  endtask

  task automatic test_if_fetch();
    @(negedge clk); valid_if_i = 1; addr_if_i = 64'h1004; #2;
    checks++; if (ready_if_o !== 1'b1 || ready_dmem_o !== 1'b0) begin failures++; $display("[TB] FAIL fetch_grant got=%0b%0b exp=10", ready_if_o, ready_dmem_o); end
    @(negedge clk); valid_if_i = 0; ready_bus_i = 1; #2;
    checks++; if (valid_bus_o !== 1'b1 || addr_bus_o !== 64'h1004) begin failures++; $display("[TB] FAIL fetch_bus_req got=%0b/%h exp=1/1004", valid_bus_o, addr_bus_o); end
    checks++; if (w_en_bus_o !== 1'b0 || busy_o !== 1'b1) begin failures++; $display("[TB] FAIL fetch_wen_busy got=%0b/%0b exp=0/1", w_en_bus_o, busy_o); end
    @(negedge clk); ready_bus_i = 0; valid_bus_rsp_i = 1; rdata_bus_i = 64'hAAAA_BBBB_CCCC_DDDD;
    ready_if_rsp_i = 1; ready_dmem_rsp_i = 1; #2;
    checks++; if (valid_bus_o !== 1'b0) begin failures++; $display("[TB] FAIL fetch_bus_in_rsp got=%0b exp=0", valid_bus_o); end
    checks++; if (valid_if_rsp_o !== 1'b1 || rdata_if_o !== 32'hAAAA_BBBB) begin failures++; $display("[TB] FAIL fetch_rsp got=%0b/%h exp=1/aaaabbbb", valid_if_rsp_o, rdata_if_o); end
    checks++; if (valid_dmem_rsp_o !== 1'b0 || ready_bus_rsp_o !== 1'b1) begin failures++; $display("[TB] FAIL fetch_rsp_route got=%0b/%0b exp=0/1", valid_dmem_rsp_o, ready_bus_rsp_o); end
    @(negedge clk); idle_inputs(); #2;
    checks++; if (busy_o !== 1'b0 || valid_dmem_rsp_o !== 1'b0) begin failures++; $display("[TB] FAIL fetch_done got=%0b/%0b exp=0/0", busy_o, valid_dmem_rsp_o); end
    modelLastDmem = 0;
  endtask

  task automatic test_round_robin();
    bit          expDmem;
    logic [63:0] expAddr, data;
    do_reset();
    for (int t = 0; t < 4; t++) begin
      @(negedge clk); idle_inputs();
      valid_if_i = 1; valid_dmem_i = 1;
      addr_if_i = 64'h100 + 64'(t) * 8; addr_dmem_i = 64'h900 + 64'(t) * 8; #2;
      expDmem = !modelLastDmem;
      checks++; if (ready_dmem_o !== expDmem || ready_if_o !== !expDmem) begin failures++; $display("[TB] FAIL rr_grant_%0d got=%0b%0b exp=%0b%0b", t, ready_if_o, ready_dmem_o, !expDmem, expDmem); end
      expAddr = expDmem ? addr_dmem_i : addr_if_i;
      modelLastDmem = expDmem;
      @(negedge clk); ready_bus_i = 1; #2;
      checks++; if (valid_bus_o !== 1'b1 || addr_bus_o !== expAddr) begin failures++; $display("[TB] FAIL rr_bus_%0d got=%0b/%h exp=1/%h", t, valid_bus_o, addr_bus_o, expAddr); end
      checks++; if (ready_if_o !== 1'b0 || ready_dmem_o !== 1'b0) begin failures++; $display("[TB] FAIL rr_no_grant_busy_%0d got=%0b%0b exp=00", t, ready_if_o, ready_dmem_o); end
      @(negedge clk); ready_bus_i = 0; valid_bus_rsp_i = 1; data = {$urandom, $urandom};
      rdata_bus_i = data; ready_if_rsp_i = 1; ready_dmem_rsp_i = 1; #2;
      checks++; if (valid_dmem_rsp_o !== expDmem || valid_if_rsp_o !== !expDmem) begin failures++; $display("[TB] FAIL rr_rsp_%0d got=%0b%0b exp=%0b%0b", t, valid_if_rsp_o, valid_dmem_rsp_o, !expDmem, expDmem); end
    end
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_store_stall();
    @(negedge clk); idle_inputs();
    valid_dmem_i = 1; w_en_dmem_i = 1; addr_dmem_i = 64'h80; wdata_dmem_i = 64'h1234; #2;
    checks++; if (ready_dmem_o !== 1'b1) begin failures++; $display("[TB] FAIL store_grant got=%0b exp=1", ready_dmem_o); end
    modelLastDmem = 1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); valid_dmem_i = 0; w_en_dmem_i = 0; addr_dmem_i = 64'hDEAD; wdata_dmem_i = 64'hBEEF;
      ready_bus_i = (c == 3); #2;
      checks++; if (valid_bus_o !== 1'b1 || w_en_bus_o !== 1'b1 || addr_bus_o !== 64'h80 || wdata_bus_o !== 64'h1234) begin
        failures++; $display("[TB] FAIL store_hold_%0d got=%0b/%0b/%h/%h exp=1/1/80/1234", c, valid_bus_o, w_en_bus_o, addr_bus_o, wdata_bus_o); end
    end
    @(negedge clk); ready_bus_i = 0; valid_bus_rsp_i = 1; ready_if_rsp_i = 1; ready_dmem_rsp_i = 1; #2;
    checks++; if (valid_dmem_rsp_o !== 1'b1 || valid_if_rsp_o !== 1'b0) begin failures++; $display("[TB] FAIL store_ack got=%0b%0b exp=01", valid_if_rsp_o, valid_dmem_rsp_o); end
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_rsp_backpressure();
    @(negedge clk); idle_inputs(); valid_dmem_i = 1; addr_dmem_i = 64'h40; #2;
    checks++; if (ready_dmem_o !== 1'b1) begin failures++; $display("[TB] FAIL bp_grant got=%0b exp=1", ready_dmem_o); end
    modelLastDmem = 1;
    @(negedge clk); valid_dmem_i = 0; ready_bus_i = 1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); ready_bus_i = 0; valid_bus_rsp_i = 1; rdata_bus_i = 64'h0123_4567_89AB_CDEF;
      ready_dmem_rsp_i = 0; ready_if_rsp_i = 1; valid_if_i = 1; #2;
      checks++; if (ready_bus_rsp_o !== 1'b0 || ready_if_o !== 1'b0 || busy_o !== 1'b1 || valid_dmem_rsp_o !== 1'b1) begin
        failures++; $display("[TB] FAIL bp_hold_%0d got=%0b/%0b/%0b/%0b exp=0/0/1/1", c, ready_bus_rsp_o, ready_if_o, busy_o, valid_dmem_rsp_o); end
    end
    @(negedge clk); ready_dmem_rsp_i = 1; #2;
    checks++; if (ready_bus_rsp_o !== 1'b1 || rdata_dmem_o !== 64'h0123_4567_89AB_CDEF) begin failures++; $display("[TB] FAIL bp_release got=%0b/%h exp=1/0123456789abcdef", ready_bus_rsp_o, rdata_dmem_o); end
    @(negedge clk); valid_bus_rsp_i = 0; ready_dmem_rsp_i = 0; #2;
    checks++; if (ready_if_o !== 1'b1) begin failures++; $display("[TB] FAIL bp_next_grant got=%0b exp=1", ready_if_o); end
    modelLastDmem = 0;
    @(negedge clk); idle_inputs(); ready_bus_i = 1;
    @(negedge clk); idle_inputs(); valid_bus_rsp_i = 1; ready_if_rsp_i = 1;
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_reset_mid();
    @(negedge clk); idle_inputs(); valid_if_i = 1; addr_if_i = 64'h2000;
    @(negedge clk); ready_bus_i = 0; #2;
    checks++; if (valid_bus_o !== 1'b1) begin failures++; $display("[TB] FAIL rstmid_in_req got=%0b exp=1", valid_bus_o); end
    #1 rst_n = 0;
    #1;
    checks++; if (valid_bus_o !== 1'b0 || busy_o !== 1'b0 || ready_if_o !== 1'b0 || ready_bus_rsp_o !== 1'b0) begin
      failures++; $display("[TB] FAIL rstmid_async got=%0b/%0b/%0b/%0b exp=0/0/0/0", valid_bus_o, busy_o, ready_if_o, ready_bus_rsp_o); end
    @(negedge clk); rst_n = 1; modelLastDmem = 0; valid_if_i = 1; addr_if_i = 64'h300C; #2;
    checks++; if (ready_if_o !== 1'b1 || valid_if_rsp_o !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_fresh_grant got=%0b/%0b exp=1/0", ready_if_o, valid_if_rsp_o); end
    @(negedge clk); valid_if_i = 0; ready_bus_i = 1; #2;
    checks++; if (valid_bus_o !== 1'b1 || addr_bus_o !== 64'h300C) begin failures++; $display("[TB] FAIL rstmid_fresh_bus got=%0b/%h exp=1/300c", valid_bus_o, addr_bus_o); end
    @(negedge clk); ready_bus_i = 0; valid_bus_rsp_i = 1; rdata_bus_i = 64'h5555_6666_7777_8888; ready_if_rsp_i = 1; #2;
    checks++; if (valid_if_rsp_o !== 1'b1 || rdata_if_o !== 32'h5555_6666) begin failures++; $display("[TB] FAIL rstmid_fresh_rsp got=%0b/%h exp=1/55556666", valid_if_rsp_o, rdata_if_o); end
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_back_to_back();
    bit busAccepted = 0;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      @(negedge clk); valid_if_i = 1; addr_if_i = 64'h4000 + 64'(c) * 4; ready_bus_i = 1;
      ready_if_rsp_i = 1; valid_bus_rsp_i = busAccepted; rdata_bus_i = {$urandom, $urandom}; #2;
      checks++; if (ready_if_o !== (c % 3 == 0) || valid_bus_o !== (c % 3 == 1) || valid_if_rsp_o !== (c % 3 == 2)) begin
        failures++; $display("[TB] FAIL b2b_cycle_%0d got=%0b%0b%0b exp=%0b%0b%0b", c, ready_if_o, valid_bus_o, valid_if_rsp_o, c % 3 == 0, c % 3 == 1, c % 3 == 2); end
      busAccepted = valid_bus_o && ready_bus_i;
    end
    @(negedge clk); idle_inputs();
    modelLastDmem = 0;
  endtask

  task automatic test_random();
    int          phase = 0;
    int          txns = 0;
    bit          own = 0, expIf, expD, txWen = 0, expRspIf, expRspD, ownReady;
    logic [63:0] txAddr = '0, txWdata = '0;
    logic [31:0] expWord;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      valid_if_i = ($urandom % 2) == 0; addr_if_i = {$urandom, $urandom};
      valid_dmem_i = ($urandom % 2) == 0; addr_dmem_i = {$urandom, $urandom};
      wdata_dmem_i = {$urandom, $urandom}; w_en_dmem_i = $urandom % 2;
      ready_bus_i = $urandom % 2; rdata_bus_i = {$urandom, $urandom};
      valid_bus_rsp_i = (phase == 2) && (($urandom % 4) != 0);
      ready_if_rsp_i = $urandom % 2; ready_dmem_rsp_i = $urandom % 2;
      #2;
      expIf = (phase == 0) && valid_if_i && (!valid_dmem_i || modelLastDmem);
      expD  = (phase == 0) && valid_dmem_i && (!valid_if_i || !modelLastDmem);
      ownReady = own ? ready_dmem_rsp_i : ready_if_rsp_i;
      expRspIf = (phase == 2) && !own && valid_bus_rsp_i;
      expRspD  = (phase == 2) && own && valid_bus_rsp_i;
      checks++; if (ready_if_o !== expIf || ready_dmem_o !== expD) begin failures++; $display("[TB] FAIL rnd_grant_%0d got=%0b%0b exp=%0b%0b", c, ready_if_o, ready_dmem_o, expIf, expD); end
      checks++; if (valid_bus_o !== (phase == 1)) begin failures++; $display("[TB] FAIL rnd_bus_valid_%0d got=%0b exp=%0b", c, valid_bus_o, phase == 1); end
      if (phase == 1) begin
        checks++; if (addr_bus_o !== txAddr || w_en_bus_o !== txWen || (txWen && wdata_bus_o !== txWdata)) begin
          failures++; $display("[TB] FAIL rnd_bus_fields_%0d got=%h/%0b/%h exp=%h/%0b/%h", c, addr_bus_o, w_en_bus_o, wdata_bus_o, txAddr, txWen, txWdata); end
      end
      checks++; if (valid_if_rsp_o !== expRspIf || valid_dmem_rsp_o !== expRspD || ready_bus_rsp_o !== ((phase == 2) && ownReady)) begin
        failures++; $display("[TB] FAIL rnd_rsp_%0d got=%0b%0b%0b exp=%0b%0b%0b", c, valid_if_rsp_o, valid_dmem_rsp_o, ready_bus_rsp_o, expRspIf, expRspD, (phase == 2) && ownReady); end
      if (expRspIf) begin
        expWord = txAddr[2] ? rdata_bus_i[63:32] : rdata_bus_i[31:0];
        checks++; if (rdata_if_o !== expWord) begin failures++; $display("[TB] FAIL rnd_if_data_%0d got=%h exp=%h", c, rdata_if_o, expWord); end
      end
      if (expRspD) begin
        checks++; if (rdata_dmem_o !== rdata_bus_i) begin failures++; $display("[TB] FAIL rnd_dmem_data_%0d got=%h exp=%h", c, rdata_dmem_o, rdata_bus_i); end
      end
      case (phase)
        0: if (expIf) begin
             own = 0; txAddr = addr_if_i; txWen = 0; phase = 1; modelLastDmem = 0;
           end else if (expD) begin
             own = 1; txAddr = addr_dmem_i; txWdata = wdata_dmem_i; txWen = w_en_dmem_i; phase = 1; modelLastDmem = 1;
           end
        1: if (ready_bus_i) phase = 2;
        default: if (valid_bus_rsp_i && ownReady) begin phase = 0; txns++; end
      endcase
    end
    @(negedge clk); idle_inputs();
    checks++; if (txns < 20) begin failures++; $display("[TB] FAIL rnd_progress got=%0d exp>=20", txns); end
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    modelLastDmem = 0;
    test_reset();
    test_if_fetch();
    test_round_robin();
    test_store_stall();
    test_rsp_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
